// File: rtl/sm_addsub_param_if.sv
// Handshake and operand/result bundle for the sign-magnitude adder/subtractor.
// The master drives the request and operands; the slave returns the result and status.
interface sm_addsub_param_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] out;
  logic             overflow;
  logic             finish;
  logic             busy;

  modport master (
    output start, sub, in_a, in_b,
    input  out, overflow, finish, busy
  );

  modport slave (
    input  start, sub, in_a, in_b,
    output out, overflow, finish, busy
  );
endinterface

// File: rtl/sm_addsub_param.sv
// Sign-magnitude adder/subtractor: capture on start, resolve signs in SET,
// compute the magnitude in ADD, hold the result in FIN until start drops.
module sm_addsub_param #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 nRST,
  sm_addsub_param_if.slave     bus
);
  localparam int MW = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SET, ADD, FIN} state_t;

  state_t          state_reg, state_next;
  logic [MW-1:0]   a_mag_reg, b_mag_reg;
  logic            a_sign_reg, b_sign_reg, sub_reg;
  logic [MW-1:0]   big_reg, small_reg;
  logic            op_sub_reg, res_sign_reg;
  logic [WIDTH-1:0] out_reg;
  logic            overflow_reg;

  logic            eff_b_sign;
  logic [MW:0]     sum;
  logic [MW-1:0]   diff;
  logic [MW-1:0]   res_mag;
  logic            res_ovf;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SET;
      SET:     state_next = ADD;
      ADD:     state_next = FIN;
      FIN:     if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    bus.busy   = (state_reg != IDLE);
    bus.finish = (state_reg == FIN);
  end

  assign bus.out      = out_reg;
  assign bus.overflow = overflow_reg;

  assign eff_b_sign = b_sign_reg ^ sub_reg;
  assign sum        = {1'b0, big_reg} + {1'b0, small_reg};
  assign diff       = big_reg - small_reg;

  always_comb begin
    res_mag = diff;
    res_ovf = 1'b0;
    if (!op_sub_reg) begin
      res_ovf = sum[MW];
      res_mag = (sum[MW] && SATURATE) ? {MW{1'b1}} : sum[MW-1:0];
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      a_sign_reg   <= 1'b0;
      b_sign_reg   <= 1'b0;
      sub_reg      <= 1'b0;
      big_reg      <= '0;
      small_reg    <= '0;
      op_sub_reg   <= 1'b0;
      res_sign_reg <= 1'b0;
      out_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          a_mag_reg  <= bus.in_a[MW-1:0];
          b_mag_reg  <= bus.in_b[MW-1:0];
          a_sign_reg <= bus.in_a[MW];
          b_sign_reg <= bus.in_b[MW];
          sub_reg    <= bus.sub;
        end
        SET: begin
          // Order operands so the subtract path is always larger minus smaller
          if (a_sign_reg == eff_b_sign) begin
            op_sub_reg   <= 1'b0;
            big_reg      <= a_mag_reg;
            small_reg    <= b_mag_reg;
            res_sign_reg <= a_sign_reg;
          end else if (a_mag_reg >= b_mag_reg) begin
            op_sub_reg   <= 1'b1;
            big_reg      <= a_mag_reg;
            small_reg    <= b_mag_reg;
            res_sign_reg <= a_sign_reg;
          end else begin
            op_sub_reg   <= 1'b1;
            big_reg      <= b_mag_reg;
            small_reg    <= a_mag_reg;
            res_sign_reg <= eff_b_sign;
          end
        end
        ADD: begin
          // A zero magnitude is always emitted as +0
          out_reg      <= {(res_mag != '0) && res_sign_reg, res_mag};
          overflow_reg <= res_ovf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sm_addsub_param.sv
// Drives three instances (16-bit wrap, 16-bit saturate, 8-bit wrap) in lockstep
// and compares each against an arithmetic sign-magnitude reference model.
module tb_sm_addsub_param;
  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  sm_addsub_param_if #(.WIDTH(16)) ia ();
  sm_addsub_param_if #(.WIDTH(16)) ib ();
  sm_addsub_param_if #(.WIDTH(8))  ic ();

  sm_addsub_param #(.WIDTH(16), .SATURATE(1'b0)) dut_a (.clk(clk), .nRST(nRST), .bus(ia));
  sm_addsub_param #(.WIDTH(16), .SATURATE(1'b1)) dut_b (.clk(clk), .nRST(nRST), .bus(ib));
  sm_addsub_param #(.WIDTH(8),  .SATURATE(1'b0)) dut_c (.clk(clk), .nRST(nRST), .bus(ic));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, result}; signed values are handled as sign plus magnitude integers
  function automatic logic [32:0] model(input int w, input bit sat,
                                        input logic [31:0] a, input logic [31:0] b, input bit s);
    longint maxm, ma, mb, m;
    bit sa, sb, sg, ov;
    maxm = (longint'(1) << (w - 1)) - 1;
    ma = longint'(a) & maxm;
    mb = longint'(b) & maxm;
    sa = a[w-1];
    sb = b[w-1] ^ s;
    ov = 1'b0;
    if (sa == sb) begin
      m  = ma + mb;
      sg = sa;
      if (m > maxm) begin
        ov = 1'b1;
        m  = sat ? maxm : m - (maxm + 1);
      end
    end else if (ma >= mb) begin
      m  = ma - mb;
      sg = sa;
    end else begin
      m  = mb - ma;
      sg = sb;
    end
    if (m == 0) sg = 1'b0;
    return {ov, 32'(m | (longint'(sg) << (w - 1)))};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] a8, input logic [7:0] b8, input logic s);
    ia.in_a = a;  ia.in_b = b;  ia.sub = s;
    ib.in_a = a;  ib.in_b = b;  ib.sub = s;
    ic.in_a = a8; ic.in_b = b8; ic.sub = s;
  endtask

  task automatic set_start(input logic v);
    ia.start = v; ib.start = v; ic.start = v;
  endtask

  task automatic check_result(input string tag, input logic [32:0] ea,
                              input logic [32:0] eb, input logic [32:0] ec);
    chk({tag, " out16w"}, {16'h0, ia.out}, ea[31:0]);
    chk({tag, " ovf16w"}, {31'h0, ia.overflow}, {31'h0, ea[32]});
    chk({tag, " out16s"}, {16'h0, ib.out}, eb[31:0]);
    chk({tag, " ovf16s"}, {31'h0, ib.overflow}, {31'h0, eb[32]});
    chk({tag, " out8"},   {24'h0, ic.out}, ec[31:0]);
    chk({tag, " ovf8"},   {31'h0, ic.overflow}, {31'h0, ec[32]});
  endtask

  // One transaction; hold = extra FIN cycles with start high, chg = disturb inputs after capture
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic [7:0] a8, input logic [7:0] b8, input logic s,
                    input int hold, input bit chg);
    logic [32:0] ea, eb, ec;
    ea = model(16, 1'b0, {16'h0, a}, {16'h0, b}, s);
    eb = model(16, 1'b1, {16'h0, a}, {16'h0, b}, s);
    ec = model(8,  1'b0, {24'h0, a8}, {24'h0, b8}, s);
    @(negedge clk);
    drive(a, b, a8, b8, s);
    set_start(1'b1);
    @(negedge clk);
    chk({tag, " busy_set"}, {31'h0, ia.busy}, 32'h1);
    chk({tag, " fin_set"},  {31'h0, ia.finish}, 32'h0);
    if (hold == 0) set_start(1'b0);
    if (chg) drive(16'h1234, $urandom, 8'h12, $urandom, ~s);
    @(negedge clk);
    chk({tag, " busy_add"}, {31'h0, ib.busy}, 32'h1);
    chk({tag, " fin_add"},  {31'h0, ib.finish}, 32'h0);
    @(negedge clk);
    chk({tag, " fin"}, {29'h0, ia.finish, ib.finish, ic.finish}, 32'h7);
    check_result(tag, ea, eb, ec);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold_fin"},  {31'h0, ia.finish & ia.busy}, 32'h1);
      chk({tag, " hold_out"},  {16'h0, ia.out}, ea[31:0]);
    end
    set_start(1'b0);
    @(negedge clk);
    chk({tag, " idle"}, {26'h0, ia.finish, ia.busy, ib.finish, ib.busy, ic.finish, ic.busy}, 32'h0);
    check_result({tag, " held"}, ea, eb, ec);
  endtask

  initial begin
    set_start(1'b0);
    drive(16'h0, 16'h0, 8'h0, 8'h0, 1'b0);
    #2;
    chk("rst_out", {ia.out, ib.out}, 32'h0);
    chk("rst_flags", {26'h0, ia.overflow, ia.finish, ia.busy, ic.overflow, ic.finish, ic.busy}, 32'h0);
    @(negedge clk);
    nRST = 1'b1;

    op("add",    16'h0005, 16'h0003, 8'h05, 8'h03, 1'b0, 0, 1'b0);
    chk("add_const", {16'h0, ia.out}, 32'h0008);
    op("sub_neg", 16'h0003, 16'h0005, 8'h03, 8'h05, 1'b1, 0, 1'b0);
    chk("sub_neg_const", {16'h0, ia.out}, 32'h8002);
    op("neg_add", 16'h8005, 16'h8003, 8'h85, 8'h83, 1'b0, 0, 1'b0);
    op("eq_sub",  16'h0005, 16'h0005, 8'h05, 8'h05, 1'b1, 0, 1'b0);
    op("ovf",     16'h7FFF, 16'h0001, 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    chk("ovf_sat_const", {16'h0, ib.out}, 32'h7FFF);
    op("ovf_neg", 16'hFFFF, 16'h0001, 8'hFF, 8'h01, 1'b1, 0, 1'b0);
    chk("ovf_neg_sat_const", {16'h0, ib.out}, 32'hFFFF);
    op("negzero", 16'h8000, 16'h0000, 8'h80, 8'h00, 1'b0, 0, 1'b1);
    op("hold",    16'h0123, 16'h8022, 8'h23, 8'h92, 1'b0, 10, 1'b0);

    for (int n = 0; n < 40; n++) begin
      op("rand", 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
         1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    // Abort in ADD: the preceding op leaves nonzero results to be cleared
    op("pre_rst", 16'h0011, 16'h0022, 8'h11, 8'h22, 1'b0, 0, 1'b0);
    @(negedge clk);
    drive(16'h0100, 16'h0200, 8'h10, 8'h20, 1'b0);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    @(negedge clk);
    #1 nRST = 1'b0;
    #1;
    chk("abort_out", {ia.out, ib.out}, 32'h0);
    chk("abort_out8", {24'h0, ic.out}, 32'h0);
    chk("abort_flags", {26'h0, ia.overflow, ia.finish, ia.busy, ic.overflow, ic.finish, ic.busy}, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    op("post_rst", 16'h0085, 16'h0002, 8'h85, 8'h02, 1'b0, 0, 1'b0);
    chk("post_rst_const8", {24'h0, ic.out}, 32'h83);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
